// File: rtl/uart_sender_pkg.sv
// Shared types and sizing for the UART word sender: FSM state encoding and bytes-per-word.
`default_nettype none

package uart_sender_pkg;

  localparam int DEF_NB_DATA    = 32;
  localparam int DEF_N_BITS     = 8;
  localparam int BYTES_PER_WORD = DEF_NB_DATA / DEF_N_BITS;
  localparam int NB_BYTE_CNT    = $clog2(BYTES_PER_WORD + 1);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    READ    = 4'd1,
    WAIT_RD = 4'd2,
    LOAD    = 4'd3,
    SEND    = 4'd4,
    WAIT_TX = 4'd5,
    NEXT    = 4'd6,
    FINISH  = 4'd7,
    CKSUM   = 4'd8
  } state_t;

endpackage

`default_nettype wire

// File: rtl/uart_word_sender_shifter.sv
// word_byte_shifter: loadable MSB-first word shift register with a remaining-byte counter.
`default_nettype none

module word_byte_shifter
  import uart_sender_pkg::*;
#(
  parameter int NB_DATA = DEF_NB_DATA,
  parameter int N_BITS  = DEF_N_BITS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               shift,
  input  logic [NB_DATA-1:0] data_in,
  output logic [N_BITS-1:0]  byte_out,
  output logic               last
);

  localparam int BPW   = NB_DATA / N_BITS;
  localparam int CNT_W = $clog2(BPW + 1);

  logic [NB_DATA-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load) begin
      shreg_d = data_in;
      cnt_d   = CNT_W'(BPW);
    end else if (shift) begin
      shreg_d = shreg_q << N_BITS;
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign byte_out = shreg_q[NB_DATA-1 -: N_BITS];
  assign last     = (cnt_q == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/uart_word_sender.sv
// uart_word_sender: reads a block of words from a source and streams them MSB-first as bytes to tx_uart.
// Optional trailing XOR checksum byte when UART_SENDER_CHECKSUM_EN is defined.
`default_nettype none

module uart_word_sender
  import uart_sender_pkg::*;
#(
  parameter int NB_DATA   = 32,
  parameter int N_BITS    = 8,
  parameter int NB_ADDR   = 7,
  parameter int NB_COUNT  = 8,
  parameter int ADDR_STEP = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start_i,
  input  logic [NB_ADDR-1:0]  base_addr_i,
  input  logic [NB_COUNT-1:0] n_words_i,
  output logic                rd_en_o,
  output logic [NB_ADDR-1:0]  rd_addr_o,
  input  logic [NB_DATA-1:0]  rd_data_i,
  output logic                tx_start_o,
  output logic [N_BITS-1:0]   tx_data_o,
  input  logic                tx_done_tick_i,
  output logic                busy_o,
  output logic                done_o
);

  state_t                state_q, state_d;
  state_t                tail_state;
  logic [NB_ADDR-1:0]    addr_q, addr_d;
  logic [NB_COUNT-1:0]   words_left_q, words_left_d;
  logic [N_BITS-1:0]     byte_out;
  logic                  last_byte;
  logic                  sh_load;
  logic                  sh_shift;
  logic                  start_ok;

  assign start_ok = (state_q == IDLE) && start_i;

`ifdef UART_SENDER_CHECKSUM_EN
  logic [N_BITS-1:0] cksum_q, cksum_d;
  logic              ck_phase_q, ck_phase_d;

  assign tail_state = CKSUM;
  assign sh_shift   = (state_q == WAIT_TX) && tx_done_tick_i && !ck_phase_q;

  // XOR accumulates each data byte as it is launched; the checksum byte itself is excluded.
  always_comb begin
    cksum_d    = cksum_q;
    ck_phase_d = ck_phase_q;
    if (start_ok) begin
      cksum_d    = '0;
      ck_phase_d = 1'b0;
    end else if (state_q == SEND) begin
      cksum_d = cksum_q ^ byte_out;
    end else if (state_q == CKSUM) begin
      ck_phase_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cksum_q    <= '0;
      ck_phase_q <= 1'b0;
    end else begin
      cksum_q    <= cksum_d;
      ck_phase_q <= ck_phase_d;
    end
  end
`else
  assign tail_state = FINISH;
  assign sh_shift   = (state_q == WAIT_TX) && tx_done_tick_i;
`endif

  assign sh_load = (state_q == LOAD);

  word_byte_shifter #(
    .NB_DATA (NB_DATA),
    .N_BITS  (N_BITS)
  ) u_shifter (
    .clock    (clock),
    .reset    (reset),
    .load     (sh_load),
    .shift    (sh_shift),
    .data_in  (rd_data_i),
    .byte_out (byte_out),
    .last     (last_byte)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      words_left_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      words_left_q <= words_left_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (n_words_i == '0) ? tail_state : READ;
      READ:    state_d = WAIT_RD;
      WAIT_RD: state_d = LOAD;
      LOAD:    state_d = SEND;
      SEND:    state_d = WAIT_TX;
      WAIT_TX: begin
        if (tx_done_tick_i) begin
`ifdef UART_SENDER_CHECKSUM_EN
          if (ck_phase_q) state_d = FINISH;
          else
`endif
          if (!last_byte) state_d = SEND;
          else if (words_left_q > NB_COUNT'(1)) state_d = NEXT;
          else state_d = tail_state;
        end
      end
      NEXT:    state_d = READ;
      FINISH:  state_d = IDLE;
`ifdef UART_SENDER_CHECKSUM_EN
      CKSUM:   state_d = WAIT_TX;
`endif
      default: state_d = IDLE;
    endcase
  end

  // NEXT is only reached with more than one word left, so the count cannot underflow.
  always_comb begin
    addr_d       = addr_q;
    words_left_d = words_left_q;
    if (start_ok) begin
      addr_d       = base_addr_i;
      words_left_d = n_words_i;
    end else if (state_q == NEXT) begin
      addr_d       = addr_q + NB_ADDR'(ADDR_STEP);
      words_left_d = words_left_q - 1'b1;
    end
  end

  always_comb begin
    rd_en_o    = (state_q == READ);
    tx_start_o = (state_q == SEND);
    tx_data_o  = byte_out;
    busy_o     = (state_q != IDLE) && (state_q != FINISH);
    done_o     = (state_q == FINISH);
`ifdef UART_SENDER_CHECKSUM_EN
    if (state_q == CKSUM) tx_start_o = 1'b1;
    if ((state_q == CKSUM) || ck_phase_q) tx_data_o = cksum_q;
`endif
  end

  assign rd_addr_o = addr_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_word_sender.sv
// Scoreboard bench for uart_word_sender: word source and tx_uart responders plus a byte/address reference model.
`default_nettype none
`timescale 1ns/1ps

module tb_uart_word_sender;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic [6:0]  base_addr_i = '0;
  logic [7:0]  n_words_i = '0;
  logic        rd_en_o;
  logic [6:0]  rd_addr_o;
  logic [31:0] rd_data_i = '0;
  logic        tx_start_o;
  logic [7:0]  tx_data_o;
  logic        tx_done_tick_i = 1'b0;
  logic        busy_o;
  logic        done_o;

  uart_word_sender dut (
    .clock          (clock),
    .reset          (reset),
    .start_i        (start_i),
    .base_addr_i    (base_addr_i),
    .n_words_i      (n_words_i),
    .rd_en_o        (rd_en_o),
    .rd_addr_o      (rd_addr_o),
    .rd_data_i      (rd_data_i),
    .tx_start_o     (tx_start_o),
    .tx_data_o      (tx_data_o),
    .tx_done_tick_i (tx_done_tick_i),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [128];
  logic [7:0]  exp_bytes [$];
  logic [6:0]  exp_addrs [$];
  logic [7:0]  last_xor = '0;
  int          n_checks = 0;
  int          n_err = 0;
  int          done_seen = 0;
  int          bytes_seen = 0;
  bit          inject_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: got unexpected/missing event, required the opposite", name);
  endtask

  // Source: registered read, output held until the next strobe.
  always @(posedge clock) if (rd_en_o) rd_data_i <= mem[rd_addr_o];

  // tx_uart stand-in: byte completes 1..4 cycles after tx_start, data must stay stable meanwhile.
  logic [7:0] held = '0;
  bit         pend = 1'b0;
  int         dly = 0;
  always @(negedge clock) begin
    tx_done_tick_i = inject_done;
    if (reset) begin
      pend = 1'b0;
    end else if (pend) begin
      if (dly == 0) begin
        chk("tx_hold", 32'(tx_data_o), 32'(held));
        tx_done_tick_i = 1'b1;
        pend = 1'b0;
      end else begin
        dly--;
      end
    end else if (tx_start_o) begin
      held = tx_data_o;
      pend = 1'b1;
      dly  = $urandom_range(0, 3);
    end
  end

  // Monitor: every strobe the DUT presents consumes one expectation.
  always @(negedge clock) begin
    if (!reset) begin
      if (rd_en_o) begin
        if (exp_addrs.size() == 0) fail("unexpected_rd");
        else chk("rd_addr", 32'(rd_addr_o), 32'(exp_addrs.pop_front()));
      end
      if (tx_start_o) begin
        bytes_seen++;
        if (exp_bytes.size() == 0) fail("unexpected_tx");
        else chk("tx_byte", 32'(tx_data_o), 32'(exp_bytes.pop_front()));
      end
      if (done_o) begin
        chk("busy_at_done", 32'(busy_o), 32'd0);
        chk("bytes_left_at_done", 32'(exp_bytes.size()), 32'd0);
        chk("addrs_left_at_done", 32'(exp_addrs.size()), 32'd0);
        done_seen++;
      end
    end
  end

  // Reference: word w of the block lives at (base + w) mod 128 and goes out high byte first.
  task automatic expect_dump(input logic [6:0] base, input int n);
    logic [7:0] x;
    logic [6:0] a;
    logic [7:0] b;
    x = '0;
    a = base;
    for (int w = 0; w < n; w++) begin
      exp_addrs.push_back(a);
      for (int k = 3; k >= 0; k--) begin
        b = 8'((mem[a] >> (8 * k)) & 32'hFF);
        exp_bytes.push_back(b);
        x = x ^ b;
      end
      a = a + 7'd1;
    end
    last_xor = x;
`ifdef UART_SENDER_CHECKSUM_EN
    exp_bytes.push_back(x);
`endif
  endtask

  task automatic run(input logic [6:0] base, input logic [7:0] n);
    logic exp_busy;
    expect_dump(base, int'(n));
`ifdef UART_SENDER_CHECKSUM_EN
    exp_busy = 1'b1;
`else
    exp_busy = (n != 8'd0);
`endif
    @(posedge clock); #1;
    start_i = 1'b1; base_addr_i = base; n_words_i = n;
    @(posedge clock); #1;
    start_i = 1'b0; base_addr_i = 7'($urandom); n_words_i = 8'($urandom);
    chk("busy_after_start", 32'(busy_o), 32'(exp_busy));
  endtask

  task automatic wait_done(input int target, input string name);
    int c;
    c = 0;
    while (done_seen < target && c < 2000) begin
      @(posedge clock); #1;
      c++;
    end
    if (done_seen < target) fail(name);
  endtask

  task automatic wait_bytes(input int target, input string name);
    int c;
    c = 0;
    while (bytes_seen < target && c < 500) begin
      @(posedge clock); #1;
      c++;
    end
    if (bytes_seen < target) fail(name);
  endtask

  initial begin
    int tgt;
    int b0;
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    mem[7'h10] = 32'hDEADBEEF;
    mem[7'h7F] = 32'h01020304;
    mem[7'h00] = 32'h05060708;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_rd_en", 32'(rd_en_o), 32'd0);
    chk("rst_tx_start", 32'(tx_start_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr_o), 32'd0);
    chk("rst_tx_data", 32'(tx_data_o), 32'd0);
    reset = 1'b0;

    // Single word DE AD BE EF.
    tgt = done_seen + 1;
    run(7'h10, 8'd1);
    wait_done(tgt, "t1_done_timeout");
    chk("t1_xor", 32'(last_xor), 32'h22);

    // Address wrap 0x7F -> 0x00.
    tgt = done_seen + 1;
    run(7'h7F, 8'd2);
    wait_done(tgt, "t2_done_timeout");

    // Empty dump.
    tgt = done_seen + 1;
    run(7'h05, 8'd0);
`ifndef UART_SENDER_CHECKSUM_EN
    @(posedge clock); #1;
    chk("t3_done_latency", 32'(done_seen), 32'(tgt));
`endif
    wait_done(tgt, "t3_done_timeout");

    // Start re-pulsed mid-word must be ignored.
    tgt = done_seen + 1;
    b0 = bytes_seen;
    run(7'h20, 8'd1);
    wait_bytes(b0 + 2, "t5_byte2_timeout");
    start_i = 1'b1; base_addr_i = 7'h33; n_words_i = 8'd5;
    @(posedge clock); #1;
    start_i = 1'b0;
    wait_done(tgt, "t5_done_timeout");
    chk("t5_byte_count", 32'(bytes_seen - b0), 32'(exp_bytes.size() == 0 ?
`ifdef UART_SENDER_CHECKSUM_EN
      5
`else
      4
`endif
      : 0));

    // Stray tx_done_tick in IDLE.
    inject_done = 1'b1;
    @(posedge clock); #1;
    inject_done = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    chk("t5_idle_busy", 32'(busy_o), 32'd0);
    chk("t5_idle_done_count", 32'(done_seen), 32'(tgt));

    // Reset while waiting on byte 2.
    tgt = done_seen;
    b0 = bytes_seen;
    run(7'h40, 8'd3);
    wait_bytes(b0 + 2, "t6_byte2_timeout");
    reset = 1'b1;
    exp_bytes.delete();
    exp_addrs.delete();
    @(posedge clock); #1;
    chk("t6_tx_start", 32'(tx_start_o), 32'd0);
    chk("t6_busy", 32'(busy_o), 32'd0);
    chk("t6_rd_en", 32'(rd_en_o), 32'd0);
    chk("t6_no_done", 32'(done_seen), 32'(tgt));
    reset = 1'b0;
    tgt = done_seen + 1;
    run(7'h41, 8'd1);
    wait_done(tgt, "t6_fresh_timeout");

    // Random blocks.
    for (int r = 0; r < 10; r++) begin
      logic [6:0] base;
      logic [7:0] n;
      base = 7'($urandom_range(0, 127));
      n    = 8'($urandom_range(1, 5));
      for (int w = 0; w < int'(n); w++) mem[7'(int'(base) + w)] = $urandom;
      tgt = done_seen + 1;
      run(base, n);
      wait_done(tgt, "rand_done_timeout");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
